ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, operand/result width; RADDR_W, default 5, register address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 valid_i  input  1  instruction present in EX.
REQ-005 flush_i  input  1  kill current EX instruction and abort any multi-cycle operation.
REQ-006 aluop_i  input  8  operation code, from the `EXE_*_OP set in define.v.
REQ-007 reg1_i, reg2_i  input  DATA_W each  operands.
REQ-008 wreg_i  input  1  write-enable request.
REQ-009 waddr_i  input  RADDR_W  destination register.
REQ-010 wreg_o  output  1  write enable.
REQ-011 waddr_o  output  RADDR_W  destination register.
REQ-012 wdata_o  output  DATA_W  write data.
REQ-013 ov_o  output  1  ADD/SUB overflow.
REQ-014 stall_o  output  1  hold the pipeline at EX.
REQ-015 hi_o, lo_o  output  DATA_W each  architectural HI/LO registers.

Function
REQ-016 Single-cycle ops SHALL be combinational: AND, OR, XOR, NOR, ADD, ADDIU, SUB, SUBU, SLT, SLTU, MFHI (wdata_o=hi_o), MFLO (wdata_o=lo_o); SLT/SLTU SHALL zero-extend a 1-bit result.
REQ-017 ov_o SHALL be 1 only for ADD/SUB with signed overflow; wreg_o SHALL then be 0.
REQ-018 Otherwise wreg_o SHALL equal wreg_i & valid_i & ~flush_i, and waddr_o SHALL equal waddr_i.
REQ-019 MTHI/MTLO SHALL load reg1_i into HI/LO at the clock edge when valid_i & ~flush_i & ~stall_o.
REQ-020 MULT, MULTU, DIV and DIVU SHALL use a sequential unit with FSM states IDLE, BUSY and DONE, and wreg_o SHALL be 0 for them.
REQ-021 Start: in IDLE, valid_i & ~flush_i & a mul/div op SHALL latch the operands and the sign info, load a counter with DATA_W, and go to BUSY.
REQ-022 Multiply SHALL be radix-2 shift-add over magnitudes, one bit per cycle, giving a 2*DATA_W product.
REQ-023 A signed MULT SHALL negate the product when the operand signs differ.
REQ-024 Divide SHALL be radix-2 restoring division over magnitudes, one bit per cycle.
REQ-025 For a signed DIV, the quotient sign SHALL be sign1^sign2 and the remainder sign SHALL be sign1.
REQ-026 Divide by zero SHALL give LO (quotient) all ones and HI (remainder) equal to the dividend, with no trap and the same latency.
REQ-027 BUSY SHALL decrement the counter each cycle.
REQ-028 When the counter reaches 0, HI/LO SHALL be written at that edge (mul: HI=upper, LO=lower; div: HI=remainder, LO=quotient) and the FSM SHALL go to DONE.
REQ-029 DONE SHALL last exactly one cycle, with stall_o=0 and no new start accepted, then go to IDLE.
REQ-030 stall_o SHALL equal (IDLE & start condition) | BUSY.
REQ-031 Total stall SHALL be DATA_W+1 cycles; new HI/LO SHALL be visible on hi_o/lo_o from the DONE cycle.
REQ-032 flush_i in BUSY SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged, and drop stall_o that cycle.
REQ-033 valid_i with flush_i together SHALL start nothing and write nothing.
REQ-034 MTHI/MTLO SHALL NOT be accepted while stall_o=1, so a HI/LO write conflict is impossible.

Reset
REQ-035 rst at a clock edge SHALL force IDLE, counter=0, HI=LO=0 and the operand/partial registers to 0, aborting any operation in progress.
REQ-036 While rst=1, all combinational outputs SHALL be 0: wreg_o, wdata_o, ov_o and stall_o.

Verification
REQ-037 MULT reg1=0xFFFFFFFE, reg2=3 -> stall_o high for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; the following MFLO returns 0xFFFFFFFA.
REQ-038 DIV reg1=0xFFFFFFF9 (-7), reg2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU of the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-039 DIVU reg1=0x12345678, reg2=0 -> LO=0xFFFFFFFF, HI=0x12345678, and stall_o lasts 33 cycles.
REQ-040 ADD 0x7FFFFFFF+1 with wreg_i=1 -> ov_o=1, wreg_o=0; ADDIU with the same operands -> wdata_o=0x80000000, wreg_o=1.
REQ-041 Preload HI=0xAA, LO=0x55 via MTHI/MTLO, start MULTU, assert flush_i at BUSY cycle 10 -> HI/LO stay 0xAA/0x55, stall_o=0 next cycle, FSM in IDLE.
REQ-042 Assert rst mid-DIV, then release it -> HI=LO=0 and stall_o=0; a fresh DIV 100/7 gives LO=14, HI=2.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage ALU with a bit-serial multiply/divide unit and the HI/LO registers.
// Latency: logic/arith/move ops are combinational; MULT/MULTU/DIV/DIVU stall for DATA_W+1 cycles and the result is on hi_o/lo_o from the DONE cycle.
// Backpressure: stall_o holds the pipeline at EX while a mul/div runs; flush_i aborts it and releases the stall in the same cycle.
// Ports: clk, rst (synchronous, active-high); valid_i/flush_i/aluop_i/reg1_i/reg2_i/wreg_i/waddr_i describe the EX instruction;
//        wreg_o/waddr_o/wdata_o/ov_o form the write-back request; stall_o holds the pipeline; hi_o/lo_o are the architectural HI/LO.
module ex_muldiv #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic [7:0]         aluop_i,
  input  logic [DATA_W-1:0]  reg1_i,
  input  logic [DATA_W-1:0]  reg2_i,
  input  logic               wreg_i,
  input  logic [RADDR_W-1:0] waddr_i,
  output logic               wreg_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               ov_o,
  output logic               stall_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);
  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_NOR_OP   = 8'h27;
  localparam logic [7:0] EXE_ADD_OP   = 8'h20;
  localparam logic [7:0] EXE_SUB_OP   = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
  localparam logic [7:0] EXE_SLT_OP   = 8'h2a;
  localparam logic [7:0] EXE_SLTU_OP  = 8'h2b;
  localparam logic [7:0] EXE_ADDIU_OP = 8'h56;
  localparam logic [7:0] EXE_MULT_OP  = 8'h18;
  localparam logic [7:0] EXE_MULTU_OP = 8'h19;
  localparam logic [7:0] EXE_DIV_OP   = 8'h1a;
  localparam logic [7:0] EXE_DIVU_OP  = 8'h1b;
  localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
  localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
  localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
  localparam logic [7:0] EXE_MTLO_OP  = 8'h13;

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;      // mul: running product; div: remainder in the low half
  logic [2*DATA_W-1:0] opa;      // mul: shifting multiplicand; div: divisor in the low half
  logic [DATA_W-1:0]   opb;      // mul: shifting multiplier; div: dividend shifting out / quotient shifting in
  logic                is_div, neg_res, neg_rem, div0;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                live, is_md, is_div_op, is_signed, start, finish;
  logic                s1, s2;
  logic [DATA_W-1:0]   mag1, mag2;

  assign live      = valid_i & ~flush_i & ~rst;
  assign is_md     = aluop_i inside {EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
  assign is_div_op = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_DIV_OP);
  assign start     = (state == IDLE) & live & is_md;
  assign finish    = (state == BUSY) & ~flush_i & (cnt == CNT_W'(1));
  assign stall_o   = ~rst & (start | ((state == BUSY) & ~flush_i));

  // The serial unit works on magnitudes; signs are re-applied when the result is stored.
  assign s1   = is_signed & reg1_i[DATA_W-1];
  assign s2   = is_signed & reg2_i[DATA_W-1];
  assign mag1 = s1 ? (~reg1_i + 1'b1) : reg1_i;
  assign mag2 = s2 ? (~reg2_i + 1'b1) : reg2_i;

  // One step of shift-add multiply and of restoring divide.
  logic [2*DATA_W-1:0] mul_acc_nx, prod;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;

  assign mul_acc_nx = opb[0] ? (acc + opa) : acc;
  assign trial      = {acc[DATA_W-1:0], opb[DATA_W-1]} - {1'b0, opa[DATA_W-1:0]};
  // A borrow out of the top bit means the divisor did not fit: keep the shifted remainder.
  assign rem_nx     = trial[DATA_W] ? {acc[DATA_W-2:0], opb[DATA_W-1]} : trial[DATA_W-1:0];
  assign quo_nx     = {opb[DATA_W-2:0], ~trial[DATA_W]};
  assign prod       = neg_res ? (~mul_acc_nx + 1'b1) : mul_acc_nx;
  // With a zero divisor the remainder path already reproduces the dividend; only the quotient is forced.
  assign quo_fix    = div0 ? '1 : (neg_res ? (~quo_nx + 1'b1) : quo_nx);
  assign rem_fix    = neg_rem ? (~rem_nx + 1'b1) : rem_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (flush_i) state_nx = IDLE;
               else if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (start) begin
      cnt     <= CNT_W'(DATA_W);
      acc     <= '0;
      is_div  <= is_div_op;
      neg_res <= s1 ^ s2;
      neg_rem <= s1;
      div0    <= (reg2_i == '0);
      if (is_div_op) begin
        opa <= {{DATA_W{1'b0}}, mag2};
        opb <= mag1;
      end else begin
        opa <= {{DATA_W{1'b0}}, mag1};
        opb <= mag2;
      end
    end else if (state == BUSY) begin
      if (flush_i) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (is_div) begin
          acc <= {{DATA_W{1'b0}}, rem_nx};
          opb <= quo_nx;
        end else begin
          acc <= mul_acc_nx;
          opa <= opa << 1;
          opb <= opb >> 1;
        end
      end
    end
  end

  // MTHI/MTLO are refused while stalled, so they can never collide with a mul/div result.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (finish) begin
      if (is_div) begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end else begin
        hi_q <= prod[2*DATA_W-1:DATA_W];
        lo_q <= prod[DATA_W-1:0];
      end
    end else if (live & ~stall_o) begin
      if (aluop_i == EXE_MTHI_OP) hi_q <= reg1_i;
      if (aluop_i == EXE_MTLO_OP) lo_q <= reg1_i;
    end
  end

  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              ovf_add, ovf_sub, ovf;

  assign sum     = reg1_i + reg2_i;
  assign diff    = reg1_i - reg2_i;
  assign ovf_add = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) && (sum[DATA_W-1] != reg1_i[DATA_W-1]);
  assign ovf_sub = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) && (diff[DATA_W-1] != reg1_i[DATA_W-1]);

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (aluop_i)
      EXE_AND_OP:   alu_res = reg1_i & reg2_i;
      EXE_OR_OP:    alu_res = reg1_i | reg2_i;
      EXE_XOR_OP:   alu_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:   alu_res = ~(reg1_i | reg2_i);
      EXE_ADD_OP:   begin alu_res = sum;  ovf = ovf_add; end
      EXE_ADDIU_OP: alu_res = sum;
      EXE_SUB_OP:   begin alu_res = diff; ovf = ovf_sub; end
      EXE_SUBU_OP:  alu_res = diff;
      EXE_SLT_OP:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP:  alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
      EXE_MFHI_OP:  alu_res = hi_q;
      EXE_MFLO_OP:  alu_res = lo_q;
      default:      alu_res = '0;
    endcase
  end

  assign wreg_o  = live & wreg_i & ~is_md & ~ovf;
  assign ov_o    = live & ovf;
  assign wdata_o = rst ? '0 : alu_res;
  assign waddr_o = waddr_i;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  localparam int W  = 32;
  localparam int AW = 5;

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h22;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2a;
  localparam logic [7:0] OP_SLTU  = 8'h2b;
  localparam logic [7:0] OP_ADDIU = 8'h56;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1a;
  localparam logic [7:0] OP_DIVU  = 8'h1b;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;

  logic          clk = 1'b0;
  logic          rst, valid_i, flush_i, wreg_i;
  logic [7:0]    aluop_i;
  logic [W-1:0]  reg1_i, reg2_i;
  logic [AW-1:0] waddr_i;
  logic          wreg_o, ov_o, stall_o;
  logic [AW-1:0] waddr_o;
  logic [W-1:0]  wdata_o, hi_o, lo_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_W(W), .RADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wreg_i(wreg_i), .waddr_i(waddr_i),
    .wreg_o(wreg_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .ov_o(ov_o),
    .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [7:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic bit is_alu(input logic [7:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_ADDIU, OP_SUB, OP_SUBU,
                      OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO};
  endfunction

  // Reference mul/div result as {HI, LO}, straight from integer arithmetic.
  function automatic logic [63:0] md_ref(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      OP_MULT:  begin q = sa * sb; res = q; end
      OP_MULTU: begin uq = ua * ub; res = uq; end
      OP_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      OP_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic alu_ref(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hi, input logic [W-1:0] lo,
                         output logic [W-1:0] wd, output bit ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    wd = '0;
    ov = 1'b0;
    case (op)
      OP_AND:   wd = a & b;
      OP_OR:    wd = a | b;
      OP_XOR:   wd = a ^ b;
      OP_NOR:   wd = ~(a | b);
      OP_ADD:   begin s = sa + sb; wd = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      OP_ADDIU: wd = a + b;
      OP_SUB:   begin s = sa - sb; wd = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      OP_SUBU:  wd = a - b;
      OP_SLT:   wd = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:  wd = (a < b) ? 32'd1 : 32'd0;
      OP_MFHI:  wd = hi;
      OP_MFLO:  wd = lo;
      default:  wd = '0;
    endcase
  endtask

  // Behavioural model: architectural HI/LO plus how many stall cycles of a mul/div remain.
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0; m_ok <= 1'b1;
    end else if (m_ok) begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush_i) m_left <= 0;
        else if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_left <= 0; m_done <= 1'b1;
        end else m_left <= m_left - 1;
      end else if (valid_i && !flush_i) begin
        if (is_md(aluop_i)) begin
          if (!m_done) begin
            m_left <= W;
            {p_hi, p_lo} <= md_ref(aluop_i, reg1_i, reg2_i);
          end
        end else begin
          if (aluop_i == OP_MTHI) m_hi <= reg1_i;
          if (aluop_i == OP_MTLO) m_lo <= reg1_i;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [W-1:0] e_wd;
    bit e_ov, e_live, e_stall, e_wreg;
    #2;
    if (m_ok) begin
      alu_ref(aluop_i, reg1_i, reg2_i, m_hi, m_lo, e_wd, e_ov);
      e_live = valid_i && !flush_i && !rst;
      if (rst) e_stall = 1'b0;
      else if (m_left > 0) e_stall = !flush_i;
      else e_stall = !m_done && e_live && is_md(aluop_i);
      e_wreg = e_live && wreg_i && !is_md(aluop_i) && !e_ov;
      chk("stall_o", {63'h0, stall_o}, {63'h0, e_stall});
      chk("wreg_o", {63'h0, wreg_o}, {63'h0, e_wreg});
      chk("ov_o", {63'h0, ov_o}, {63'h0, e_live && e_ov});
      if (rst) chk("wdata_o_in_reset", {32'h0, wdata_o}, 64'h0);
      else if (is_alu(aluop_i)) chk("wdata_o", {32'h0, wdata_o}, {32'h0, e_wd});
      if (!rst) chk("waddr_o", {59'h0, waddr_o}, {59'h0, waddr_i});
      chk("hi_o", {32'h0, hi_o}, {32'h0, m_hi});
      chk("lo_o", {32'h0, lo_o}, {32'h0, m_lo});
    end
  end

  task automatic drive(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit v, input bit f, input bit w, input logic [AW-1:0] ad);
    @(negedge clk);
    aluop_i = op; reg1_i = a; reg2_i = b; valid_i = v; flush_i = f; wreg_i = w; waddr_i = ad;
  endtask

  // Present a mul/div and hold it until stall_o drops; returns the number of stalled cycles.
  // Leaves the bench inside the DONE cycle.
  task automatic run_md(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int n);
    drive(op, a, b, 1'b1, 1'b0, 1'b0, 5'd0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      #3;
      if (!stall_o) break;
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [7:0] op_tab [0:17] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU,
                                OP_ADDIU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0]    c_op;
    logic [W-1:0]  c_a, c_b;
    bit            c_w, held;
    logic [AW-1:0] c_ad;

    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; wreg_i = 1'b0; aluop_i = 8'h0;
    reg1_i = '0; reg2_i = '0; waddr_i = '0;

    // Model anchors.
    chk("model_mult", md_ref(OP_MULT, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    chk("model_div", md_ref(OP_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_divu0", md_ref(OP_DIVU, 32'h1234_5678, 32'd0), 64'h1234_5678_FFFF_FFFF);

    repeat (2) @(negedge clk);
    #3;
    chk("reset_stall", {63'h0, stall_o}, 64'h0);
    chk("reset_hi", {32'h0, hi_o}, 64'h0);
    chk("reset_lo", {32'h0, lo_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run_md(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_stall_cycles", 64'(n), 64'd33);
    chk("mult_hi", {32'h0, hi_o}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'h0, lo_o}, 64'hFFFF_FFFA);
    drive(OP_MFLO, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3);
    #3;
    chk("mflo_data", {32'h0, wdata_o}, 64'hFFFF_FFFA);
    chk("mflo_wreg", {63'h0, wreg_o}, 64'h1);

    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lo", {32'h0, lo_o}, 64'hFFFF_FFFD);
    chk("div_hi", {32'h0, hi_o}, 64'hFFFF_FFFF);
    run_md(OP_DIVU, 32'hFFFF_FFF9, 32'd2, n);
    chk("divu_lo", {32'h0, lo_o}, 64'h7FFF_FFFC);
    chk("divu_hi", {32'h0, hi_o}, 64'h1);
    run_md(OP_DIVU, 32'h1234_5678, 32'd0, n);
    chk("div0_stall_cycles", 64'(n), 64'd33);
    chk("div0_lo", {32'h0, lo_o}, 64'hFFFF_FFFF);
    chk("div0_hi", {32'h0, hi_o}, 64'h1234_5678);

    drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1, 5'd5);
    #3;
    chk("add_ov", {63'h0, ov_o}, 64'h1);
    chk("add_ov_wreg", {63'h0, wreg_o}, 64'h0);
    drive(OP_ADDIU, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1, 5'd5);
    #3;
    chk("addiu_data", {32'h0, wdata_o}, 64'h8000_0000);
    chk("addiu_wreg", {63'h0, wreg_o}, 64'h1);

    // Flush during BUSY.
    drive(OP_MTHI, 32'hAA, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(OP_MTLO, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(OP_MULTU, 32'h0001_2345, 32'h0000_6789, 1'b1, 1'b0, 1'b0, 5'd0);
    repeat (9) drive(OP_MULTU, 32'h0001_2345, 32'h0000_6789, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(OP_MULTU, 32'h0001_2345, 32'h0000_6789, 1'b1, 1'b1, 1'b0, 5'd0);
    #3;
    chk("flush_stall_drop", {63'h0, stall_o}, 64'h0);
    drive(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    #3;
    chk("after_flush_stall", {63'h0, stall_o}, 64'h0);
    chk("after_flush_hi", {32'h0, hi_o}, 64'hAA);
    chk("after_flush_lo", {32'h0, lo_o}, 64'h55);
    drive(OP_MULTU, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 5'd0);
    #3;
    chk("idle_after_flush_start", {63'h0, stall_o}, 64'h1);
    drive(OP_MULTU, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 5'd0);

    // Reset in the middle of a divide.
    drive(OP_DIV, 32'd1000, 32'd3, 1'b1, 1'b0, 1'b0, 5'd0);
    repeat (10) drive(OP_DIV, 32'd1000, 32'd3, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1, 5'd2);
    rst = 1'b1;
    #3;
    chk("rst_stall", {63'h0, stall_o}, 64'h0);
    chk("rst_ov", {63'h0, ov_o}, 64'h0);
    chk("rst_wdata", {32'h0, wdata_o}, 64'h0);
    drive(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
    #3;
    chk("post_rst_hi", {32'h0, hi_o}, 64'h0);
    chk("post_rst_lo", {32'h0, lo_o}, 64'h0);
    chk("post_rst_stall", {63'h0, stall_o}, 64'h0);
    run_md(OP_DIV, 32'd100, 32'd7, n);
    chk("div100_7_lo", {32'h0, lo_o}, 64'd14);
    chk("div100_7_hi", {32'h0, hi_o}, 64'd2);

    // Random instruction stream; a stalled instruction is re-presented until released.
    held = 1'b0;
    c_op = OP_AND; c_a = '0; c_b = '0; c_w = 1'b0; c_ad = '0;
    for (int i = 0; i < 600; i++) begin
      if (held) begin
        drive(c_op, c_a, c_b, 1'b1, ($urandom_range(0, 24) == 0), c_w, c_ad);
      end else begin
        c_op = op_tab[$urandom_range(0, 17)];
        c_a  = pick_val();
        c_b  = pick_val();
        c_w  = $urandom_range(0, 1) == 1;
        c_ad = AW'($urandom);
        drive(c_op, c_a, c_b, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), c_w, c_ad);
      end
      rst = ($urandom_range(0, 199) == 0);
      #3;
      held = stall_o;
    end
    drive(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #4;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
